// File: rtl/mac_dot_accumulator_pkg.sv
// mac_pkg: shared state encoding, saturation limits and default widths for the dot-product accumulator
package mac_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;
  localparam int LEN_W_DEF = 8;
  localparam int ACC_W_DEF = 40;
endpackage

// File: rtl/mac_dot_accumulator_if.sv
// mac_dot_accumulator_if: run control, term stream and result stream of the dot-product accumulator
interface mac_dot_accumulator_if import mac_pkg::*; #(parameter int LEN_W = LEN_W_DEF) ();
  logic start;
  logic [LEN_W-1:0] len;
  logic in_valid;
  logic [31:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [31:0] out_data;
  logic out_sat;
  logic out_ready;
  logic busy;
  modport master (output start, len, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, out_sat, busy);
  modport slave (input start, len, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, out_sat, busy);
endinterface

// File: rtl/mac_dot_accumulator_acc_saturate.sv
// acc_saturate: clamps the wide signed sum to signed 32 bits and flags when clamping occurred
module acc_saturate import mac_pkg::*; #(parameter int ACC_W = ACC_W_DEF) (
  input  logic [ACC_W-1:0] sum,
  output logic [31:0]      data,
  output logic             sat
);
  // in range exactly when every bit above bit 31 matches the sign bit
  assign sat  = !(&sum[ACC_W-1:31] || !(|sum[ACC_W-1:31]));
  assign data = !sat ? sum[31:0] : sum[ACC_W-1] ? SAT_MIN : SAT_MAX;
endmodule

// File: rtl/mac_dot_accumulator.sv
// mac_dot_accumulator: sums a programmed number of signed 32-bit terms and returns one saturated result
module mac_dot_accumulator import mac_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic clk,
  input logic rst_n,
  mac_dot_accumulator_if.slave bus
);
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q, cnt;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [31:0] sat_data, data_q;
  logic sat_flag, sat_q, go, take, last;
  assign go     = state == IDLE && bus.start;
  assign take   = state == ACCUM && bus.in_valid;
  assign last   = take && cnt == len_q - 1'b1;
  assign acc_nx = acc + {{(ACC_W-32){bus.in_data[31]}}, bus.in_data};
  acc_saturate #(.ACC_W(ACC_W)) u_sat (.sum(acc_nx), .data(sat_data), .sat(sat_flag));
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx      = state;
    state_nx      = go ? (bus.len != '0 ? ACCUM : DONE)
                  : last ? DONE
                  : (state == DONE && bus.out_ready) ? IDLE : state;
    bus.in_ready  = state == ACCUM;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
    bus.out_data  = data_q;
    bus.out_sat   = sat_q;
  end
  // the result registers are only written on the final term, so they hold through DONE
  always_ff @(posedge clk)
    if (!rst_n) begin
      len_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (go) begin
      len_q  <= bus.len;
      cnt    <= '0;
      acc    <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (take) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        data_q <= sat_data;
        sat_q  <= sat_flag;
      end
    end
endmodule
